// File: rtl/ib_packer.sv
// ib_packer: packs a stream of fp16 engine results into 32-bit input-buffer FIFO words.
// Define IB_PACKER_PAD_BURST_EN to pad each blob out to a whole DRAM burst with PAD_WORD.
module ib_packer #(
    parameter int unsigned BURST_LEN = 32,
    parameter logic [31:0] PAD_WORD  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] op_num,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    input  logic        ib_full,
    output logic        ib_we,
    output logic [31:0] ib_data,
    output logic        busy,
    output logic        done
);

    localparam int unsigned AlignBits = $clog2(BURST_LEN);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StPack = 3'd1;
    localparam logic [2:0] StTail = 3'd2;
    localparam logic [2:0] StPad  = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

`ifdef IB_PACKER_PAD_BURST_EN
    localparam logic [2:0] StAfterData = StPad;
`else
    localparam logic [2:0] StAfterData = StDone;
`endif

    logic [2:0]  state_q, state_d;
    logic [15:0] op_num_q, op_num_d;
    logic [15:0] elem_cnt_q, elem_cnt_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] low_half_q, low_half_d;
    logic        ib_we_q, ib_we_d;
    logic [31:0] ib_data_q, ib_data_d;
    logic        done_q, done_d;

    logic accept;
    logic last_elem;
    logic aligned;

    assign in_ready  = (state_q == StPack) && !ib_full && (elem_cnt_q < op_num_q);
    assign accept    = in_valid && in_ready;
    assign last_elem = (elem_cnt_q == (op_num_q - 16'd1));
    assign aligned   = (word_cnt_q[AlignBits-1:0] == '0);

    assign ib_we   = ib_we_q;
    assign ib_data = ib_data_q;
    assign busy    = (state_q != StIdle);
    assign done    = done_q;

    always_comb begin
        state_d    = state_q;
        op_num_d   = op_num_q;
        elem_cnt_d = elem_cnt_q;
        word_cnt_d = word_cnt_q;
        low_half_d = low_half_q;
        ib_we_d    = 1'b0;
        ib_data_d  = ib_data_q;
        // done is a registered copy of the DONE state, so it trails DONE by one cycle
        done_d     = (state_q == StDone);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_num_d   = op_num;
                    elem_cnt_d = 16'd0;
                    word_cnt_d = 16'd0;
                    low_half_d = 16'd0;
                    state_d    = (op_num == 16'd0) ? StDone : StPack;
                end
            end
            StPack: begin
                if (accept) begin
                    elem_cnt_d = elem_cnt_q + 16'd1;
                    if (!elem_cnt_q[0]) begin
                        low_half_d = in_data;
                    end else begin
                        ib_we_d    = 1'b1;
                        ib_data_d  = {in_data, low_half_q};
                        word_cnt_d = word_cnt_q + 16'd1;
                    end
                    if (last_elem) begin
                        state_d = op_num_q[0] ? StTail : StAfterData;
                    end
                end
            end
            StTail: begin
                if (!ib_full) begin
                    ib_we_d    = 1'b1;
                    ib_data_d  = {16'h0000, low_half_q};
                    word_cnt_d = word_cnt_q + 16'd1;
                    state_d    = StAfterData;
                end
            end
            StPad: begin
                if (aligned) begin
                    state_d = StDone;
                end else if (!ib_full) begin
                    ib_we_d    = 1'b1;
                    ib_data_d  = PAD_WORD;
                    word_cnt_d = word_cnt_q + 16'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            op_num_q   <= 16'd0;
            elem_cnt_q <= 16'd0;
            word_cnt_q <= 16'd0;
            low_half_q <= 16'd0;
            ib_we_q    <= 1'b0;
            ib_data_q  <= 32'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_num_q   <= op_num_d;
            elem_cnt_q <= elem_cnt_d;
            word_cnt_q <= word_cnt_d;
            low_half_q <= low_half_d;
            ib_we_q    <= ib_we_d;
            ib_data_q  <= ib_data_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_ib_packer.sv
// Self-checking bench for ib_packer: expected FIFO words are queued at stimulus time and
// popped by a write monitor. Honours IB_PACKER_PAD_BURST_EN when computing expectations.
module tb_ib_packer;

    localparam int unsigned BurstLen = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] op_num;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        ib_full;
    logic        ib_we;
    logic [31:0] ib_data;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_we_cyc = -1;
    int words_seen = 0;

    logic [31:0] sb[$];
    logic [15:0] elems[$];
    logic [31:0] exp_word;

    ib_packer #(
        .BURST_LEN(BurstLen),
        .PAD_WORD (32'h0000_0000)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op_num  (op_num),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .ib_full (ib_full),
        .ib_we   (ib_we),
        .ib_data (ib_data),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every FIFO write must match the oldest expected word.
    always @(negedge clk) begin
        if (ib_we === 1'b1) begin
            checks++;
            last_we_cyc = cyc;
            words_seen++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got ib_data=%h, required no write", ib_data);
            end else begin
                exp_word = sb.pop_front();
                if (ib_data !== exp_word) begin
                    failures++;
                    $display("FAIL write_data: got %h, required %h", ib_data, exp_word);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // mode 0: (i+1)*0x1111, mode 1: random, mode 2: 0xABC0+i
    task automatic make_blob(input int n, input int mode);
        int words;
        elems.delete();
        for (int i = 0; i < n; i++) begin
            if (mode == 0)      elems.push_back(16'((i + 1) * 16'h1111));
            else if (mode == 1) elems.push_back(16'($urandom));
            else                elems.push_back(16'(16'hABC0 + i));
        end
        for (int i = 0; i + 1 < n; i += 2) sb.push_back({elems[i+1], elems[i]});
        if (n % 2 == 1) sb.push_back({16'h0000, elems[n-1]});
        words = (n + 1) / 2;
`ifdef IB_PACKER_PAD_BURST_EN
        while (words % BurstLen != 0) begin
            sb.push_back(32'h0000_0000);
            words++;
        end
`endif
    endtask

    task automatic start_blob(input int n);
        start  = 1'b1;
        op_num = 16'(n);
        @(negedge clk);
        start  = 1'b0;
        op_num = 16'd0;
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send_elem(input logic [15:0] d, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 200; t++) begin
            #1;
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_range(input int first, input int last, output bit all_ok);
        bit ok;
        all_ok = 1'b1;
        for (int i = first; i <= last; i++) begin
            send_elem(elems[i], ok);
            if (!ok) all_ok = 1'b0;
        end
    endtask

    task automatic wait_done(output bit seen, output int dcyc);
        seen = 1'b0;
        dcyc = -1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                dcyc = cyc;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, ib_we, busy, done} !== 4'b0000 || ib_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy/we/busy/done=%b data=%h, required 0000 data=0",
                     {in_ready, ib_we, busy, done}, ib_data);
        end
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_blob(input string name, input int n, input int mode);
        bit ok;
        bit seen;
        int dcyc;
        make_blob(n, mode);
        start_blob(n);
        send_range(0, n - 1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_accept: got an element not accepted in 200 cycles, required all", name);
        end
        wait_done(seen, dcyc);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_done: got no done pulse, required one", name);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_words: got %0d words still pending, required 0", name, sb.size());
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_width: got done=%b busy=%b, required 0 0", name, done, busy);
        end
    endtask

    task automatic test_full_burst();
        bit ok;
        bit seen;
        int dcyc;
        int c0;
        int lat;
`ifdef IB_PACKER_PAD_BURST_EN
        lat = 2;
`else
        lat = 1;
`endif
        make_blob(64, 1);
        start_blob(64);
        c0 = cyc;
        send_range(0, 63, ok);
        checks++;
        if (!ok || cyc - c0 != 64) begin
            failures++;
            $display("FAIL burst_throughput: got %0d cycles ok=%b, required 64 cycles", cyc - c0, ok);
        end
        wait_done(seen, dcyc);
        checks++;
        if (!seen || dcyc != last_we_cyc + lat) begin
            failures++;
            $display("FAIL burst_done_latency: got done at %0d last write %0d, required +%0d",
                     dcyc, last_we_cyc, lat);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL burst_words: got %0d words pending, required 0", sb.size());
        end
    endtask

    task automatic test_zero();
        int w0;
        w0 = words_seen;
        start_blob(0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL zero_done_state: got busy=%b done=%b, required 1 0", busy, done);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL zero_done_pulse: got busy=%b done=%b, required 0 1", busy, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || words_seen != w0) begin
            failures++;
            $display("FAIL zero_no_write: got done=%b writes=%0d, required 0 0", done, words_seen - w0);
        end
    endtask

    task automatic test_stall();
        bit ok;
        bit seen;
        int dcyc;
        int bad;
        make_blob(8, 0);
        start_blob(8);
        send_range(0, 1, ok);
        ib_full  = 1'b1;
        in_valid = 1'b1;
        in_data  = elems[2];
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_ready: got in_ready=%b at stall cycle %0d, required 0", in_ready, i);
            end
            @(negedge clk);
            checks++;
            if (ib_we !== 1'b0) begin
                failures++;
                $display("FAIL stall_we: got ib_we=%b at stall cycle %0d, required 0", ib_we, i);
            end
        end
        ib_full = 1'b0;
        send_range(2, 7, ok);
        wait_done(seen, dcyc);
        checks++;
        if (!seen || sb.size() != 0) begin
            failures++;
            $display("FAIL stall_sequence: got done=%b pending=%0d, required 1 0", seen, sb.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        int dcyc;
        int w0;
        make_blob(8, 0);
        sb.delete();
        sb.push_back({elems[1], elems[0]});
        sb.push_back({elems[3], elems[2]});
        start_blob(8);
        send_range(0, 4, ok);
        w0 = words_seen;
        reset    = 1'b1;
        in_valid = 1'b1;
        #1;
        checks++;
        if ({in_ready, ib_we, busy, done} !== 4'b0000 || ib_data !== 32'd0) begin
            failures++;
            $display("FAIL midreset_outputs: got rdy/we/busy/done=%b data=%h, required 0000 data=0",
                     {in_ready, ib_we, busy, done}, ib_data);
        end
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || words_seen != w0 || sb.size() != 0) begin
            failures++;
            $display("FAIL midreset_idle: got busy=%b extra_writes=%0d pending=%0d, required 0 0 0",
                     busy, words_seen - w0, sb.size());
        end
        make_blob(2, 2);
        start_blob(2);
        send_range(0, 1, ok);
        wait_done(seen, dcyc);
        checks++;
        if (!seen || sb.size() != 0) begin
            failures++;
            $display("FAIL midreset_next_blob: got done=%b pending=%0d, required 1 0", seen, sb.size());
        end
        @(negedge clk);
    endtask

    task automatic test_ignore();
        bit ok;
        bit seen;
        int dcyc;
        in_valid = 1'b1;
        in_data  = 16'h5A5A;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_ready: got in_ready=%b in IDLE, required 0", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (ib_we !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignore: got ib_we=%b busy=%b, required 0 0", ib_we, busy);
        end
        make_blob(4, 2);
        start_blob(4);
        start_blob(2);
        send_range(0, 3, ok);
        wait_done(seen, dcyc);
        checks++;
        if (!ok || !seen || sb.size() != 0) begin
            failures++;
            $display("FAIL busy_start_ignore: got ok=%b done=%b pending=%0d, required 1 1 0",
                     ok, seen, sb.size());
        end
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        op_num   = 16'd0;
        in_valid = 1'b0;
        in_data  = 16'd0;
        ib_full  = 1'b0;
        test_reset();
        test_blob("even4", 4, 0);
        test_blob("odd3", 3, 0);
        test_blob("one1", 1, 1);
        test_full_burst();
        test_zero();
        test_stall();
        test_reset_mid();
        test_ignore();
        test_blob("back_to_back", 6, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
